// File: rtl/data_mem_bus_if.sv
// Request/ready bus between the MEM stage and the data memory.
// The master issues byte/half/word accesses; the slave reports busy, ready, err and rdata.
interface data_mem_bus_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ready;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, size, sign, pc, addr, wdata,
        input  busy, ready, err, rdata
    );

    modport slave (
        input  req, we, size, sign, pc, addr, wdata,
        output busy, ready, err, rdata
    );
endinterface

// File: rtl/data_mem_bus.sv
// Data memory slave with sub-word access, sign/zero extension, wait states,
// misalignment/range error reporting and a post-reset clearing sweep.
module data_mem_bus #(
    parameter int ADDR_W         = 12,
    parameter int DEPTH          = 3072,
    parameter int WAIT           = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic           clk,
    input logic           reset,
    data_mem_bus_if.slave bus
);

    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    localparam logic [3:0]  WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'h0;

    typedef enum logic [1:0] {
        CLEAR   = 2'b00,
        IDLE    = 2'b01,
        WAITING = 2'b10,
        ACCESS  = 2'b11
    } state_t;

    state_t state_r;
    state_t state_s;

    logic [31:0]      mem_r [DEPTH];
    logic [IDX_W-1:0] clr_ptr_r;
    logic [3:0]       wait_cnt_r;

    logic        we_r;
    logic        sign_r;
    logic        err_flag_r;
    logic [1:0]  size_r;
    logic [31:0] pc_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;

    logic        ready_r;
    logic        err_r;
    logic [31:0] rdata_r;

    logic             size_err_s;
    logic             range_err_s;
    logic             req_err_s;
    logic [IDX_W-1:0] acc_idx_s;
    logic [31:0]      cur_word_s;
    logic [7:0]       byte_s;
    logic [15:0]      half_s;
    logic [31:0]      merged_s;
    logic [31:0]      load_val_s;
    logic             mem_we_s;
    logic [IDX_W-1:0] mem_idx_s;
    logic [31:0]      mem_wdata_s;

    // Alignment check of the incoming request against its access size
    always_comb begin
        size_err_s = 1'b0;
        case (bus.size)
            2'b00:   size_err_s = 1'b0;
            2'b01:   size_err_s = bus.addr[0];
            2'b10:   size_err_s = (bus.addr[1:0] != 2'b00);
            default: size_err_s = 1'b1;
        endcase
    end

    assign range_err_s = (bus.addr[31:ADDR_W+2] != {(30-ADDR_W){1'b0}}) ||
                         ({{(32-ADDR_W){1'b0}}, bus.addr[ADDR_W+1:2]} >= DEPTH_U);
    assign req_err_s   = size_err_s | range_err_s;

    assign acc_idx_s  = addr_r[IDX_W+1:2];
    assign cur_word_s = mem_r[acc_idx_s];
    assign byte_s     = cur_word_s[{addr_r[1:0], 3'b000} +: 8];
    assign half_s     = cur_word_s[{addr_r[1], 4'b0000} +: 16];

    // Store merge: only the addressed little-endian lanes take new data
    always_comb begin
        merged_s = cur_word_s;
        case (size_r)
            2'b00:   merged_s[{addr_r[1:0], 3'b000} +: 8] = wdata_r[7:0];
            2'b01:   merged_s[{addr_r[1], 4'b0000} +: 16] = wdata_r[15:0];
            2'b10:   merged_s = wdata_r;
            default: merged_s = cur_word_s;
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        load_val_s = 32'h0;
        case (size_r)
            2'b00:   load_val_s = sign_r ? {{24{byte_s[7]}}, byte_s} : {24'h0, byte_s};
            2'b01:   load_val_s = sign_r ? {{16{half_s[15]}}, half_s} : {16'h0, half_s};
            2'b10:   load_val_s = cur_word_s;
            default: load_val_s = 32'h0;
        endcase
    end

    // Array write port shared by the clearing sweep and committed stores
    always_comb begin
        mem_we_s    = 1'b0;
        mem_idx_s   = acc_idx_s;
        mem_wdata_s = merged_s;
        if (state_r == CLEAR) begin
            mem_we_s    = 1'b1;
            mem_idx_s   = clr_ptr_r;
            mem_wdata_s = 32'h0;
        end else if ((state_r == ACCESS) && we_r && !err_flag_r) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array; no reset so contents survive except through the sweep
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_idx_s] <= mem_wdata_s;
        end
    end

    // Next-state logic; errored requests skip the wait counter
    always_comb begin
        state_s = state_r;
        case (state_r)
            CLEAR: begin
                if (clr_ptr_r == IDX_W'(DEPTH - 1)) begin
                    state_s = IDLE;
                end else begin
                    state_s = CLEAR;
                end
            end
            IDLE: begin
                if (!bus.req) begin
                    state_s = IDLE;
                end else if (req_err_s || (WAIT == 0)) begin
                    state_s = ACCESS;
                end else begin
                    state_s = WAITING;
                end
            end
            WAITING: begin
                if (wait_cnt_r == 4'h0) begin
                    state_s = ACCESS;
                end else begin
                    state_s = WAITING;
                end
            end
            ACCESS:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register, request capture, wait counting and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_ptr_r  <= {IDX_W{1'b0}};
            wait_cnt_r <= 4'h0;
            ready_r    <= 1'b0;
            err_r      <= 1'b0;
            rdata_r    <= 32'h0;
            we_r       <= 1'b0;
            sign_r     <= 1'b0;
            err_flag_r <= 1'b0;
            size_r     <= 2'b00;
            pc_r       <= 32'h0;
            addr_r     <= 32'h0;
            wdata_r    <= 32'h0;
        end else begin
            state_r <= state_s;
            ready_r <= 1'b0;
            case (state_r)
                CLEAR: clr_ptr_r <= clr_ptr_r + IDX_W'(1);
                IDLE: begin
                    if (bus.req) begin
                        we_r       <= bus.we;
                        size_r     <= bus.size;
                        sign_r     <= bus.sign;
                        pc_r       <= bus.pc;
                        addr_r     <= bus.addr;
                        wdata_r    <= bus.wdata;
                        err_flag_r <= req_err_s;
                        wait_cnt_r <= WAIT_M1;
                    end
                end
                WAITING: begin
                    if (wait_cnt_r != 4'h0) begin
                        wait_cnt_r <= wait_cnt_r - 4'h1;
                    end
                end
                ACCESS: begin
                    ready_r <= 1'b1;
                    err_r   <= err_flag_r;
                    if (err_flag_r) begin
                        rdata_r <= 32'h0;
                    end else if (!we_r) begin
                        rdata_r <= load_val_s;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Store trace in the datapath's write-log format
    always @(posedge clk) begin
        if ((state_r == ACCESS) && we_r && !err_flag_r) begin
            $display("@%h: *%h <= %h", pc_r, {addr_r[31:2], 2'b00}, merged_s);
        end
    end
`endif

    assign bus.busy  = (state_r != IDLE);
    assign bus.ready = ready_r;
    assign bus.err   = err_r;
    assign bus.rdata = rdata_r;

endmodule

// File: doc/data_mem_bus.md
# data_mem_bus

Parametrised data memory for the MIPS datapath. It replaces the single-cycle word-only data memory with a request/ready slave that supports byte, halfword and word stores and loads with sign or zero extension, a configurable number of wait states, and misalignment/range error reporting. A reset-triggered sweep clears the array to zero. It sits between the MEM stage and the pipeline stall logic.

## Interface
- `ADDR_W`, 12: word-index width; the word index is `addr[ADDR_W+1:2]`.
- `DEPTH`, 3072: number of 32-bit words; must satisfy DEPTH ≤ 2^ADDR_W.
- `WAIT`, 0: extra wait cycles before each valid access completes; range 0–15.
- `CLEAR_ON_RESET`, 1: 1 = sweep the array to zero after reset; 0 = skip the sweep.

- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in 1: access request; sampled only when `busy`=0.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `sign` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `pc` in 32: PC of the issuing instruction; used only for the write trace.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `busy` out 1: high whenever `state` ≠ IDLE; requests are ignored while high.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: valid with `ready`; 1 = access rejected.
- `rdata` out 32: load result, valid with `ready`; holds its value until the next completion.

## Operation
- FSM states: CLEAR, IDLE, WAITING, ACCESS.
- **Reset** (`reset`=0) forces:
  - state = CLEAR if CLEAR_ON_RESET, else IDLE;
  - clear pointer = 0, wait counter = 0;
  - `ready`=0, `err`=0, `rdata`=0.
  - Array contents are not touched asynchronously.
- **CLEAR**: writes word[ptr] = 0 and increments ptr each cycle. After the edge that clears word DEPTH−1, state goes to IDLE.
- **IDLE**, `req`=1: the request (we, size, sign, pc, addr, wdata) is latched and checked.
  - Error conditions:
    - size=11;
    - size=01 with addr[0]=1;
    - size=10 with addr[1:0]≠0;
    - addr[31:ADDR_W+2]≠0;
    - word index ≥ DEPTH.
  - On error: state goes to ACCESS with the error flag set; the wait counter is bypassed.
  - No error, WAIT=0: state goes to ACCESS.
  - No error, WAIT>0: state goes to WAITING with counter = WAIT−1.
- **WAITING**: the counter decrements each cycle. When the counter is 0, state goes to ACCESS.
- **ACCESS**: one edge; state returns to IDLE.
  - Always: `ready`<=1 for one cycle; `err`<= error flag.
  - Error: no array write; `rdata`<=0.
  - Valid store:
    - read-modify-write of the addressed word; only the addressed lanes change;
    - `$display("@%h: *%h <= %h", pc, {addr[31:2],2'b00}, merged_word)`.
  - Valid load: the lanes are extracted, then extended per `sign` into `rdata`.
- **Byte lanes** (little-endian):
  - byte at addr[1:0]=b occupies bits [8b+7:8b];
  - half at addr[1]=h occupies bits [16h+15:16h].
- Word loads and stores ignore `sign`.

## Timing
- Request accepted at edge N; `ready` is high during the cycle after edge N+1+WAIT. Valid-access latency = WAIT+1 edges.
- Errored accesses complete at edge N+1 regardless of WAIT.
- The store commits on the completion edge, not on the acceptance edge.
- `busy` is high from edge N until the completion edge. In the `ready` cycle `busy`=0, so a new request may be accepted at the next edge.
- Peak throughput: one access per WAIT+2 cycles.
- Clear sweep: `busy` is high for exactly DEPTH cycles after reset deassertion.
- `req` during CLEAR, WAITING or ACCESS is dropped. The requester must hold `req` until it sees `busy`=0 at an edge.
- Reset mid-access: the access is aborted, no write occurs, and no `ready` is produced. The sweep restarts at word 0.
- Reset mid-sweep: the sweep restarts at word 0.

## Test plan
- **Sweep**, CLEAR_ON_RESET=1, DEPTH=16:
  - before reset, load garbage words through the bus;
  - release reset;
  - `busy` stays high exactly 16 cycles, then every word reads 0.
- **Sub-word stores**, WAIT=0:
  - sw 0x11223344 @0x10; sb 0xAB @0x11; sh 0xBEEF @0x12;
  - lw @0x10 returns 0xBEEFAB44;
  - trace lines show 0x11223344, 0x1122AB44, 0xBEEFAB44.
- **Extension**, word 0x80FF7F01:
  - lb @+3 → 0xFFFFFF80; lbu @+3 → 0x00000080;
  - lh @+2 → 0xFFFF80FF; lhu @+0 → 0x00007F01.
- **Errors**:
  - lw @0x2, sh @0x1 and size=11 each give `ready`=1, `err`=1, `rdata`=0 one cycle after acceptance, with no write;
  - addr = DEPTH·4 also gives `err`=1.
- **Wait states**, WAIT=3:
  - `ready` arrives 4 edges after acceptance;
  - `req` pulses during `busy` are ignored;
  - the next request is accepted in the `ready` cycle's following edge.
- **Reset abort**, WAIT=3:
  - assert `reset`=0 two cycles into a sw of 0xDEADBEEF;
  - no `ready`;
  - after the sweep the word reads 0.
